// File: rtl/ddr_pixel_in_packer.sv
// Streams one frame of DEPTH pixels from the direction BRAMs as 9*DATA_WIDTH-bit AXIS beats.
// Latency: start -> rd_en +1 cycle -> tvalid +3 cycles; 1 beat/clock when tready is held high.
// Backpressure: a 2-entry FIFO absorbs stalls; reads are issued only while a FIFO slot is guaranteed.
module ddr_pixel_in_packer #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                         m00_axis_aclk,
    input  logic                         m00_axis_aresetn,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_en,
    output logic [ADDRESS_WIDTH-1:0]     rd_addr,
    input  logic [DATA_WIDTH-1:0]        n_in,
    input  logic [DATA_WIDTH-1:0]        null_in,
    input  logic [DATA_WIDTH-1:0]        ne_in,
    input  logic [DATA_WIDTH-1:0]        e_in,
    input  logic [DATA_WIDTH-1:0]        se_in,
    input  logic [DATA_WIDTH-1:0]        s_in,
    input  logic [DATA_WIDTH-1:0]        sw_in,
    input  logic [DATA_WIDTH-1:0]        w_in,
    input  logic [DATA_WIDTH-1:0]        nw_in,
    output logic                         m00_axis_tvalid,
    output logic [9*DATA_WIDTH-1:0]      m00_axis_tdata,
    output logic [9*DATA_WIDTH/8-1:0]    m00_axis_tstrb,
    output logic                         m00_axis_tlast,
    input  logic                         m00_axis_tready
);

    localparam int TW = 9 * DATA_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [TW-1:0]             fifo_dat [2];
    logic [1:0]                fifo_last;
    logic                      wr_ptr;
    logic                      rd_ptr;
    logic [1:0]                count;
    logic                      inflight;
    logic                      inflight_last;
    logic                      pop;
    logic                      issue_last;
    logic [2:0]                occ_after;
    logic [TW-1:0]             bram_dat;

    // Direction values packed LSB first: n, null, ne, e, se, s, sw, w, nw.
    assign bram_dat = {nw_in, w_in, sw_in, s_in, se_in, e_in, ne_in, null_in, n_in};

    assign m00_axis_tvalid = (count != 2'd0);
    assign m00_axis_tdata  = fifo_dat[rd_ptr];
    assign m00_axis_tlast  = fifo_last[rd_ptr];
    assign m00_axis_tstrb  = '1;
    assign pop             = m00_axis_tvalid & m00_axis_tready;
    assign issue_last      = rd_en && (rd_addr == LAST_ADDR);

    // Occupancy after this edge, counting the read whose data lands on it.
    assign occ_after = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

    // Next-state, read issue, and status outputs.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                rd_en = (occ_after < 3'd2);
                if (rd_en && (rd_addr == LAST_ADDR)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (occ_after == 3'd0) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, read address counter and read-latency tracking.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state         <= S_IDLE;
            rd_addr       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_nxt;
            inflight      <= rd_en;
            inflight_last <= issue_last;
            if (state == S_DONE)
                rd_addr <= '0;
            else if (rd_en && !issue_last)
                rd_addr <= rd_addr + ADDRESS_WIDTH'(1);
        end
    end

    // FIFO pointers and occupancy; a push and pop together leave count unchanged.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            fifo_last <= 2'b00;
        end else begin
            if (inflight) begin
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    // FIFO data storage captures BRAM output the cycle after each read.
    always_ff @(posedge m00_axis_aclk) begin
        if (inflight) fifo_dat[wr_ptr] <= bram_dat;
    end

endmodule

// File: tb/tb_ddr_pixel_in_packer.sv
module tb_ddr_pixel_in_packer;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0, start1 = 1'b0;
    logic         tready = 1'b0, tready1 = 1'b0;
    logic         busy, done, rd_en, tvalid, tlast;
    logic         busy1, done1, rd_en1, tvalid1, tlast1;
    logic [11:0]  rd_addr, rd_addr1;
    logic [143:0] tdata, tdata1;
    logic [17:0]  tstrb, tstrb1;
    logic [15:0]  bd  [9];
    logic [15:0]  bd1 [9];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Synchronous BRAM models: direction k of pixel p holds p*16+k.
    always @(posedge clk) begin
        for (int k = 0; k < 9; k++) begin
            if (rd_en)  bd[k]  <= 16'(int'(rd_addr) * 16 + k);
            if (rd_en1) bd1[k] <= 16'(int'(rd_addr1) * 16 + k);
        end
    end

    ddr_pixel_in_packer #(.DATA_WIDTH(16), .DEPTH(2500), .ADDRESS_WIDTH(12)) dut (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rstn), .start(start),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .n_in(bd[0]), .null_in(bd[1]), .ne_in(bd[2]), .e_in(bd[3]), .se_in(bd[4]),
        .s_in(bd[5]), .sw_in(bd[6]), .w_in(bd[7]), .nw_in(bd[8]),
        .m00_axis_tvalid(tvalid), .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb),
        .m00_axis_tlast(tlast), .m00_axis_tready(tready)
    );

    ddr_pixel_in_packer #(.DATA_WIDTH(16), .DEPTH(1), .ADDRESS_WIDTH(12)) dut1 (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rstn), .start(start1),
        .busy(busy1), .done(done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .n_in(bd1[0]), .null_in(bd1[1]), .ne_in(bd1[2]), .e_in(bd1[3]), .se_in(bd1[4]),
        .s_in(bd1[5]), .sw_in(bd1[6]), .w_in(bd1[7]), .nw_in(bd1[8]),
        .m00_axis_tvalid(tvalid1), .m00_axis_tdata(tdata1), .m00_axis_tstrb(tstrb1),
        .m00_axis_tlast(tlast1), .m00_axis_tready(tready1)
    );

    function automatic logic [143:0] pack(input int p);
        logic [143:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[16*k +: 16] = 16'(p * 16 + k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: tready=1; mode 1: random tready; mode 2: tready=0 for first 100 cycles.
    // restart_beat >= 0 re-pulses start while that beat is pending.
    task automatic run_frame(input string name, input int mode, input int restart_beat);
        int beats = 0, issued = 0, dones = 0, last_cyc = -10;
        bit fin = 0, restarted = 0, prev_stall = 0;
        logic [143:0] prev_d = '0;
        logic prev_l = 1'b0;
        for (int cyc = 0; cyc < 12000 && !fin; cyc++) begin
            @(negedge clk);
            start = (cyc == 0);
            if (restart_beat >= 0 && beats == restart_beat && !restarted) begin
                start = 1'b1;
                restarted = 1;
            end
            case (mode)
                0: tready = 1'b1;
                1: tready = 1'($urandom_range(0, 1));
                default: tready = (cyc >= 100);
            endcase
            #1;
            if (mode == 0 && cyc == 0) chk({name, " busy before start"}, busy, 0);
            if (mode == 0 && cyc == 1) chk({name, " rd_en latency"}, rd_en, 1);
            if (mode == 0 && cyc == 2) chk({name, " tvalid at cycle 2"}, tvalid, 0);
            if (mode == 0 && cyc == 3) chk({name, " tvalid at cycle 3"}, tvalid, 1);
            if (mode == 2 && cyc == 99) begin
                chk({name, " reads issued under stall"}, issued, 2);
                chk({name, " tvalid under stall"}, tvalid, 1);
                chk({name, " head under stall"}, tdata, pack(0));
            end
            if (prev_stall) begin
                chk({name, " tdata held"}, tdata, prev_d);
                chk({name, " tlast held"}, tlast, prev_l);
            end
            if (rd_en) begin
                chk({name, " rd_addr"}, rd_addr, issued);
                issued++;
            end
            if (tvalid && tready) begin
                chk({name, " tdata"}, tdata, pack(beats));
                chk({name, " tlast"}, tlast, (beats == 2499));
                if (beats == 2499) last_cyc = cyc;
                beats++;
            end
            chk({name, " outstanding<=2"}, (issued - beats) <= 2, 1);
            if (done) begin
                chk({name, " done timing"}, cyc, last_cyc + 1);
                dones++;
                fin = 1;
            end
            prev_stall = tvalid && !tready;
            prev_d = tdata;
            prev_l = tlast;
        end
        chk({name, " beats"}, beats, 2500);
        chk({name, " reads"}, issued, 2500);
        chk({name, " done pulses"}, dones, 1);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({name, " idle busy"}, busy, 0);
        chk({name, " idle done"}, done, 0);
        chk({name, " idle tvalid"}, tvalid, 0);
    endtask

    initial begin
        int hs;
        #12;
        chk("reset tvalid", tvalid, 0);
        chk("reset tlast", tlast, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset rd_en", rd_en, 0);
        chk("reset rd_addr", rd_addr, 0);
        chk("tstrb ones", tstrb, 18'h3ffff);
        @(negedge clk);
        rstn = 1'b1;

        run_frame("t1_full", 0, -1);
        run_frame("t2_random", 1, -1);
        run_frame("t3_stall", 2, -1);
        run_frame("t4_restart", 0, 1000);

        // Mid-frame asynchronous reset at beat 1234.
        hs = 0;
        for (int cyc = 0; cyc < 3000 && hs < 1234; cyc++) begin
            @(negedge clk);
            start = (cyc == 0);
            tready = 1'b1;
            #1;
            if (tvalid && tready) hs++;
        end
        start = 1'b0;
        chk("t5 busy before reset", busy, 1);
        chk("t5 tvalid before reset", tvalid, 1);
        #1;
        rstn = 1'b0;
        #1;
        chk("t5 async tvalid", tvalid, 0);
        chk("t5 async busy", busy, 0);
        chk("t5 async rd_en", rd_en, 0);
        @(negedge clk);
        rstn = 1'b1;
        run_frame("t5_after_reset", 0, -1);

        // DEPTH=1 instance.
        @(negedge clk);
        start1 = 1'b1;
        tready1 = 1'b1;
        #1;
        chk("t6 idle busy", busy1, 0);
        @(negedge clk);
        start1 = 1'b0;
        #1;
        chk("t6 rd_en", rd_en1, 1);
        chk("t6 rd_addr", rd_addr1, 0);
        @(negedge clk);
        #1;
        chk("t6 no second read", rd_en1, 0);
        chk("t6 tvalid early", tvalid1, 0);
        @(negedge clk);
        #1;
        chk("t6 tvalid", tvalid1, 1);
        chk("t6 tlast", tlast1, 1);
        chk("t6 tdata", tdata1, pack(0));
        @(negedge clk);
        #1;
        chk("t6 done", done1, 1);
        chk("t6 tvalid after", tvalid1, 0);
        @(negedge clk);
        #1;
        chk("t6 back to idle", busy1, 0);
        chk("t6 done cleared", done1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
